fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, pushes {valid, pc, insn} into the IQ.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_mispredict,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        iq_full,
    output logic        iq_push,
    output logic [64:0] iq_data
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    typedef enum logic [1:0] {
        StIssue,
        StWait,
        StHold,
        StFlush
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_q, hold_d;
    logic        push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIssue;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_d     = hold_q;
        push       = 1'b0;
        imem_rmask = 4'h0;
        iq_data    = 65'b0;
        // While flushing, keep presenting the address of the request being discarded.
        imem_addr  = (state_q == StFlush) ? req_addr_q : pc_q;

        unique case (state_q)
            StIssue: begin
                imem_rmask = 4'hF;
                req_addr_d = pc_q;
                state_d    = branch_mispredict ? StFlush : StWait;
            end
            StWait: begin
                if (imem_resp) begin
                    if (branch_mispredict) begin
                        state_d = StIssue;
                    end else if (!iq_full) begin
                        push    = 1'b1;
                        iq_data = {1'b1, pc_q, imem_rdata};
                        state_d = StIssue;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = StHold;
                    end
                end else if (branch_mispredict) begin
                    state_d = StFlush;
                end
            end
            StHold: begin
                if (branch_mispredict) begin
                    state_d = StIssue;
                end else if (!iq_full) begin
                    push    = 1'b1;
                    iq_data = {1'b1, pc_q, hold_q};
                    state_d = StIssue;
                end
            end
            StFlush: begin
                if (imem_resp) begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIssue;
        endcase

        if (push) begin
            pc_d = pc_q + 32'd4;
        end
        // A redirect wins over any push and always retargets the pc.
        if (branch_mispredict) begin
            pc_d = branch_target;
        end

        if (rst) begin
            imem_rmask = 4'h0;
            push       = 1'b0;
            iq_data    = 65'b0;
        end
    end

    assign iq_push = push;

`ifdef FETCH_PERF_CNT_EN
    logic        drop;
    logic [31:0] fetched_q, flushed_q;

    // A discarded response or a dropped hold buffer each count as one flushed fetch.
    always_comb begin
        drop = 1'b0;
        if (!rst) begin
            drop = (state_q == StWait  && imem_resp && branch_mispredict) ||
                   (state_q == StHold  && branch_mispredict) ||
                   (state_q == StFlush && imem_resp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= 32'h0;
            flushed_q <= 32'h0;
        end else begin
            if (push) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (drop) begin
                flushed_q <= flushed_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic,
// all checked against a transaction-level reference model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_mispredict;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        iq_full;
    logic        iq_push;
    logic [64:0] iq_data;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC(RESET_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .branch_mispredict(branch_mispredict),
        .branch_target    (branch_target),
        .imem_addr        (imem_addr),
        .imem_rmask       (imem_rmask),
        .imem_rdata       (imem_rdata),
        .imem_resp        (imem_resp),
        .iq_full          (iq_full),
        .iq_push          (iq_push),
        .iq_data          (iq_data)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_flushed     (perf_flushed)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: what the fetcher owes the world, in transaction terms.
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_req_addr = RESET_PC;
    logic [31:0] m_word = 32'h0;
    bit          m_outstanding = 1'b0;
    bit          m_doomed = 1'b0;
    bit          m_have_word = 1'b0;
    logic [31:0] m_fetched = 32'h0;
    logic [31:0] m_flushed = 32'h0;

    // Memory responder.
    bit          mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    int          lat = 1;
    bit          lat_rand = 1'b0;

    logic        s_push;
    logic [64:0] s_data;
    logic [31:0] s_addr;
    logic [3:0]  s_rmask;
    logic [31:0] s_fetched, s_flushed;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a ^ RESET_PC) + 32'h13;
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_cycle();
        bit          issuing;
        bit          exp_push;
        logic [64:0] exp_data;
        logic [31:0] exp_addr;

        imem_resp  = 1'b0;
        imem_rdata = $urandom();
        if (mem_pending) begin
            if (mem_cnt <= 1) begin
                imem_resp   = 1'b1;
                imem_rdata  = word_of(mem_addr);
                mem_pending = 1'b0;
            end else begin
                mem_cnt--;
            end
        end

        @(negedge clk);
        s_push  = iq_push;
        s_data  = iq_data;
        s_addr  = imem_addr;
        s_rmask = imem_rmask;
`ifdef FETCH_PERF_CNT_EN
        s_fetched = perf_fetched;
        s_flushed = perf_flushed;
`else
        s_fetched = 32'h0;
        s_flushed = 32'h0;
`endif

        issuing  = !rst && !m_outstanding && !m_have_word;
        exp_push = !rst && !branch_mispredict && !iq_full &&
                   ((m_outstanding && !m_doomed && imem_resp) || m_have_word);
        exp_data = exp_push ? {1'b1, m_pc, (m_have_word ? m_word : imem_rdata)} : 65'b0;
        exp_addr = (m_outstanding && m_doomed) ? m_req_addr : m_pc;

        check("rmask", {61'b0, s_rmask}, {61'b0, (issuing ? 4'hF : 4'h0)});
        check("push", {64'b0, s_push}, {64'b0, exp_push});
        check("data", s_data, exp_data);
        if (!rst) begin
            check("addr", {33'b0, s_addr}, {33'b0, exp_addr});
`ifdef FETCH_PERF_CNT_EN
            check("perf_fetched", {33'b0, s_fetched}, {33'b0, m_fetched});
            check("perf_flushed", {33'b0, s_flushed}, {33'b0, m_flushed});
`endif
        end

        if (!rst && imem_rmask == 4'hF) begin
            mem_pending = 1'b1;
            mem_cnt     = lat_rand ? int'($urandom_range(1, 3)) : lat;
            mem_addr    = imem_addr;
        end

        if (rst) begin
            m_pc          = RESET_PC;
            m_outstanding = 1'b0;
            m_have_word   = 1'b0;
            m_word        = 32'h0;
            m_fetched     = 32'h0;
            m_flushed     = 32'h0;
        end else if (issuing) begin
            m_outstanding = 1'b1;
            m_doomed      = branch_mispredict;
            m_req_addr    = m_pc;
            if (branch_mispredict) m_pc = branch_target;
        end else if (m_outstanding) begin
            if (imem_resp) begin
                m_outstanding = 1'b0;
                if (m_doomed || branch_mispredict) begin
                    m_flushed++;
                    if (branch_mispredict) m_pc = branch_target;
                end else if (!iq_full) begin
                    m_pc = m_pc + 32'd4;
                    m_fetched++;
                end else begin
                    m_have_word = 1'b1;
                    m_word      = imem_rdata;
                end
            end else if (branch_mispredict) begin
                m_doomed = 1'b1;
                m_pc     = branch_target;
            end
        end else begin
            if (branch_mispredict) begin
                m_have_word = 1'b0;
                m_pc        = branch_target;
                m_flushed++;
            end else if (!iq_full) begin
                m_have_word = 1'b0;
                m_pc        = m_pc + 32'd4;
                m_fetched++;
            end
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        branch_mispredict = 1'b0;
        branch_target     = 32'h0;
        iq_full           = 1'b0;
        imem_resp         = 1'b0;
        imem_rdata        = 32'h0;

        // Reset: no strobes while held.
        step_cycle();
        step_cycle();
        check("rst_rmask", {61'b0, s_rmask}, 65'h0);
        check("rst_push", {64'b0, s_push}, 65'h0);

        // Back-to-back fetch with 1-cycle memory: pushes on cycles 1, 3, 5.
        rst = 1'b0;
        lat = 1;
        for (int i = 0; i < 6; i++) begin
            step_cycle();
            if (i == 0) begin
                check("first_issue_rmask", {61'b0, s_rmask}, 65'hF);
                check("first_issue_addr", {33'b0, s_addr}, {33'b0, RESET_PC});
            end
            if (i % 2 == 1) begin
                check("stream_push", {64'b0, s_push}, 65'h1);
                check("stream_pc", {33'b0, s_data[63:32]},
                      {33'b0, RESET_PC + 32'(4 * (i / 2))});
            end else begin
                check("stream_idle", {64'b0, s_push}, 65'h0);
            end
        end

        // Queue full on response: hold, then push the buffered word.
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
        step_cycle();
        iq_full = 1'b1;
        step_cycle();
        check("full_resp_nopush", {64'b0, s_push}, 65'h0);
        step_cycle();
        step_cycle();
        check("hold_nopush", {64'b0, s_push}, 65'h0);
        iq_full = 1'b0;
        step_cycle();
        check("hold_push", s_data, {1'b1, RESET_PC, 32'h00000013});
        lat = 2;
        step_cycle();
        check("after_hold_addr", {33'b0, s_addr}, {33'b0, RESET_PC + 32'd4});
        check("after_hold_rmask", {61'b0, s_rmask}, 65'hF);

        // Mispredict while waiting; late response is discarded.
        branch_mispredict = 1'b1;
        branch_target     = 32'h1eceb100;
        step_cycle();
        check("wait_mp_nopush", {64'b0, s_push}, 65'h0);
        branch_mispredict = 1'b0;
        step_cycle();
        check("flush_nopush", {64'b0, s_push}, 65'h0);
        check("flush_addr", {33'b0, s_addr}, {33'b0, RESET_PC + 32'd4});
        lat = 1;
        step_cycle();
        check("redirect_addr", {33'b0, s_addr}, 65'h1eceb100);

        // Mispredict coincident with response, then double mispredict into FLUSH.
        branch_mispredict = 1'b1;
        branch_target     = 32'h1eceb200;
        step_cycle();
        check("mp_resp_nopush", {64'b0, s_push}, 65'h0);
        branch_mispredict = 1'b0;
        lat = 3;
        step_cycle();
        check("mp_resp_addr", {33'b0, s_addr}, 65'h1eceb200);
        branch_mispredict = 1'b1;
        branch_target     = 32'h1eceb300;
        step_cycle();
        branch_target     = 32'h1eceb400;
        step_cycle();
        check("flush_mp_nopush", {64'b0, s_push}, 65'h0);
        branch_mispredict = 1'b0;
        step_cycle();
        check("flush_resp_nopush", {64'b0, s_push}, 65'h0);
        lat = 1;
        step_cycle();
        check("last_target_addr", {33'b0, s_addr}, 65'h1eceb400);

        // pc wrap at the top of the address space.
        branch_mispredict = 1'b1;
        branch_target     = 32'hFFFFFFFC;
        step_cycle();
        branch_mispredict = 1'b0;
        step_cycle();
        check("wrap_issue_addr", {33'b0, s_addr}, 65'hFFFFFFFC);
        step_cycle();
        check("wrap_push", s_data, {1'b1, 32'hFFFFFFFC, word_of(32'hFFFFFFFC)});
        step_cycle();
        check("wrap_next_addr", {33'b0, s_addr}, 65'h0);

        // Four pushes, one discarded response, then reset.
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step_cycle();
        branch_mispredict = 1'b1;
        branch_target     = RESET_PC + 32'h100;
        step_cycle();
        branch_mispredict = 1'b0;
        step_cycle();
        step_cycle();
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched_4", {33'b0, s_fetched}, 65'd4);
        check("perf_flushed_1", {33'b0, s_flushed}, 65'd1);
`endif
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
        step_cycle();
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched_rst", {33'b0, s_fetched}, 65'd0);
        check("perf_flushed_rst", {33'b0, s_flushed}, 65'd0);
`endif

        // Randomized traffic against the model.
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst               = ($urandom_range(0, 199) == 0);
            branch_mispredict = ($urandom_range(0, 9) == 0);
            branch_target     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 1) * 4)
                                                            : ($urandom() & 32'hFFFFFFFC);
            iq_full           = ($urandom_range(0, 2) == 0);
            step_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
